// File: rtl/softmax_seq.sv
// softmax_seq: buffers one score vector, feeds max-subtracted clamped samples to the
// shared exponent unit, then streams the exponent words together with their sum.
module softmax_seq #(
   parameter  int N       = 8,
   parameter  int EXP_LAT = 0,
   localparam int IW      = $clog2(N),
   localparam int SW      = 47 + $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [16:0]   in_data,
   output logic [16:0]   exp_x,
   input  logic [20:0]   exp_y,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [20:0]   out_exp,
   output logic [SW-1:0] out_sum,
   output logic          out_last,
   output logic          busy
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_EXP   = 3'd2,
      S_DRAIN = 3'd3,
      S_OUT   = 3'd4
   } state_t;

   localparam logic signed [17:0] D_MIN  = -18'sd40960;
   localparam logic [IW-1:0]      LAST_I = IW'(N - 1);

   state_t             state_q, state_d;
   logic [IW-1:0]      cnt_q, cnt_d;
   logic signed [16:0] max_q, max_d;
   logic [SW-1:0]      sum_q, sum_d;
   logic [16:0]        xbuf_q [N];
   logic [16:0]        xbuf_d [N];
   logic [20:0]        ebuf_q [N];
   logic [20:0]        ebuf_d [N];

   logic               issue_s;
   logic               cap_v_s;
   logic [IW-1:0]      cap_i_s;
   logic signed [17:0] d_raw_s, d_s;
   logic [15:0]        mag_s;
   logic [46:0]        lin_s;

   assign issue_s = (state_q == S_EXP);
   assign lin_s   = {31'b0, exp_y[15:0]} << exp_y[20:16];

   // Capture tagging: issue index travels alongside the exponent unit latency.
   generate
      if (EXP_LAT == 0) begin : g_nolat
         assign cap_v_s = issue_s;
         assign cap_i_s = cnt_q;
      end else begin : g_lat
         logic [EXP_LAT-1:0] vld_q, vld_d;
         logic [IW-1:0]      pidx_q [EXP_LAT];
         logic [IW-1:0]      pidx_d [EXP_LAT];

         // Shift the issue tag one stage per cycle.
         always_comb begin
            vld_d[0]  = issue_s;
            pidx_d[0] = cnt_q;
            for (int k = 1; k < EXP_LAT; k++) begin
               vld_d[k]  = vld_q[k-1];
               pidx_d[k] = pidx_q[k-1];
            end
         end

         // Tag pipe registers.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               vld_q <= '0;
               for (int k = 0; k < EXP_LAT; k++) pidx_q[k] <= '0;
            end else begin
               vld_q <= vld_d;
               for (int k = 0; k < EXP_LAT; k++) pidx_q[k] <= pidx_d[k];
            end
         end

         assign cap_v_s = vld_q[EXP_LAT-1];
         assign cap_i_s = pidx_q[EXP_LAT-1];
      end
   endgenerate

   // Issue arithmetic: distance below the max, clamped at -10.0, sign-magnitude.
   always_comb begin
      d_raw_s = $signed({xbuf_q[cnt_q][16], xbuf_q[cnt_q]}) - $signed({max_q[16], max_q});
      if (d_raw_s < D_MIN) d_s = D_MIN;
      else                 d_s = d_raw_s;
      mag_s = 16'(-d_s);
      if (!issue_s)              exp_x = 17'h00000;
      else if (d_s == 18'sd0)    exp_x = 17'h00000;
      else                       exp_x = {1'b1, mag_s};
   end

   // Next-state, buffer writes and sum accumulation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      max_d   = max_q;
      xbuf_d  = xbuf_q;
      ebuf_d  = ebuf_q;
      if (cap_v_s) begin
         ebuf_d[cap_i_s] = exp_y;
         sum_d = sum_q + {{(SW-47){1'b0}}, lin_s};
      end else begin
         sum_d = sum_q;
      end
      case (state_q)
         S_IDLE: state_d = S_LOAD;
         S_LOAD: begin
            if (in_valid) begin
               xbuf_d[cnt_q] = in_data;
               if ((cnt_q == {IW{1'b0}}) || ($signed(in_data) > max_q)) max_d = $signed(in_data);
               else                                                       max_d = max_q;
               if (cnt_q == LAST_I) begin
                  state_d = S_EXP;
                  cnt_d   = {IW{1'b0}};
                  sum_d   = {SW{1'b0}};
               end else begin
                  cnt_d = cnt_q + IW'(1);
               end
            end else begin
               state_d = S_LOAD;
            end
         end
         S_EXP: begin
            if (cnt_q == LAST_I) begin
               cnt_d = {IW{1'b0}};
               if (EXP_LAT == 0) state_d = S_OUT;
               else              state_d = S_DRAIN;
            end else begin
               cnt_d = cnt_q + IW'(1);
            end
         end
         S_DRAIN: begin
            if (cap_v_s && (cap_i_s == LAST_I)) begin
               state_d = S_OUT;
               cnt_d   = {IW{1'b0}};
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_OUT: begin
            if (out_ready) begin
               if (cnt_q == LAST_I) begin
                  state_d = S_LOAD;
                  cnt_d   = {IW{1'b0}};
                  max_d   = 17'sd0;
               end else begin
                  cnt_d = cnt_q + IW'(1);
               end
            end else begin
               state_d = S_OUT;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, counters and buffers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= {IW{1'b0}};
         max_q   <= 17'sd0;
         sum_q   <= {SW{1'b0}};
         for (int k = 0; k < N; k++) begin
            xbuf_q[k] <= 17'h00000;
            ebuf_q[k] <= 21'h000000;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         max_q   <= max_d;
         sum_q   <= sum_d;
         for (int k = 0; k < N; k++) begin
            xbuf_q[k] <= xbuf_d[k];
            ebuf_q[k] <= ebuf_d[k];
         end
      end
   end

   // Handshake and output words decoded from registered state only.
   always_comb begin
      in_ready  = (state_q == S_LOAD);
      out_valid = (state_q == S_OUT);
      busy      = (state_q == S_EXP) || (state_q == S_DRAIN) || (state_q == S_OUT);
      if (state_q == S_OUT) begin
         out_exp  = ebuf_q[cnt_q];
         out_sum  = sum_q;
         out_last = (cnt_q == LAST_I);
      end else begin
         out_exp  = 21'h000000;
         out_sum  = {SW{1'b0}};
         out_last = 1'b0;
      end
   end

endmodule

// File: tb/tb_softmax_seq.sv
// tb_softmax_seq: randomized self-checking bench; two instances (EXP_LAT 0 and 2) share
// one stimulus path selected by sel and are compared against a plain softmax-front model.
module tb_softmax_seq;

   localparam int N  = 4;
   localparam int SW = 47 + $clog2(N);

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic [16:0] in_data = 17'h0;
   logic out_ready = 1'b0;
   bit   sel = 1'b0;
   int   mode = 0;
   int   cur_idx = 0;

   logic in_ready0, in_ready1, out_valid0, out_valid1, out_last0, out_last1, busy0, busy1;
   logic [16:0] exp_x0, exp_x1;
   logic [20:0] exp_y0, exp_y1, out_exp0, out_exp1;
   logic [SW-1:0] out_sum0, out_sum1;
   logic [20:0] y1_q [2];

   logic in_ready_s, out_valid_s, out_last_s, busy_s;
   logic [16:0] exp_x_s;
   logic [20:0] out_exp_s;
   logic [SW-1:0] out_sum_s;

   logic [16:0] vx [N];
   logic [16:0] m_ex [N];
   logic [20:0] m_ey [N];
   logic [63:0] m_sum;
   bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   // Exponent unit stub: mode 0 hash, 1/2 constants, 3 returns issue index.
   function automatic logic [20:0] stub_f(input logic [16:0] x, input int idx, input int md);
      case (md)
         0:       return {x[4:0] ^ x[16:12], x[15:0] ^ 16'hA5C3};
         1:       return {5'd0, 16'h8000};
         2:       return {5'd4, 16'hFFFF};
         default: return {5'd0, 16'(idx)};
      endcase
   endfunction

   assign exp_y0 = stub_f(exp_x0, cur_idx, mode);
   assign exp_y1 = y1_q[1];

   always @(posedge clk) begin
      y1_q[0] <= stub_f(exp_x1, cur_idx, mode);
      y1_q[1] <= y1_q[0];
   end

   softmax_seq #(.N(N), .EXP_LAT(0)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(in_ready0), .in_data(in_data),
      .exp_x(exp_x0), .exp_y(exp_y0), .out_valid(out_valid0), .out_ready(out_ready & ~sel),
      .out_exp(out_exp0), .out_sum(out_sum0), .out_last(out_last0), .busy(busy0));

   softmax_seq #(.N(N), .EXP_LAT(2)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(in_ready1), .in_data(in_data),
      .exp_x(exp_x1), .exp_y(exp_y1), .out_valid(out_valid1), .out_ready(out_ready & sel),
      .out_exp(out_exp1), .out_sum(out_sum1), .out_last(out_last1), .busy(busy1));

   assign in_ready_s  = sel ? in_ready1  : in_ready0;
   assign out_valid_s = sel ? out_valid1 : out_valid0;
   assign out_last_s  = sel ? out_last1  : out_last0;
   assign busy_s      = sel ? busy1      : busy0;
   assign exp_x_s     = sel ? exp_x1     : exp_x0;
   assign out_exp_s   = sel ? out_exp1   : out_exp0;
   assign out_sum_s   = sel ? out_sum1   : out_sum0;

   task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t sel=%0d)", tag, obs, exp, $time, sel);
      end
   endtask

   // Reference: max, difference clamp, sign-magnitude, stub result, linearised sum.
   task automatic compute_model;
      int mx, xi, d;
      mx = $signed(vx[0]);
      for (int i = 1; i < N; i++) begin
         xi = $signed(vx[i]);
         if (xi > mx) mx = xi;
      end
      m_sum = 64'd0;
      for (int i = 0; i < N; i++) begin
         xi = $signed(vx[i]);
         d  = xi - mx;
         if (d < -40960) d = -40960;
         if (d == 0) m_ex[i] = 17'h00000;
         else        m_ex[i] = {1'b1, 16'(-d)};
         m_ey[i] = stub_f(m_ex[i], i, mode);
         m_sum   = m_sum + (64'(m_ey[i][15:0]) << m_ey[i][20:16]);
      end
   endtask

   task automatic rand_vec;
      int base;
      base = $urandom_range(0, 32'h1FFFF);
      for (int i = 0; i < N; i++) begin
         if ($urandom_range(0, 4) == 0) vx[i] = 17'($urandom);
         else                           vx[i] = 17'(base + $urandom_range(0, 32'h3000));
      end
   endtask

   task automatic do_reset;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      #1;
      chk_eq("rst_in_ready", in_ready_s, 0);
      chk_eq("rst_exp_x", exp_x_s, 0);
      chk_eq("rst_out_valid", out_valid_s, 0);
      chk_eq("rst_out_exp", out_exp_s, 0);
      chk_eq("rst_out_sum", out_sum_s, 0);
      chk_eq("rst_out_last", out_last_s, 0);
      chk_eq("rst_busy", busy_s, 0);
      @(negedge clk);
      chk_eq("rst_hold_ready", in_ready_s, 0);
      rst = 1'b0;
      @(negedge clk);
      chk_eq("rst_release_load", in_ready_s, 1);
   endtask

   // One vector: load, check issues, wait for output, drain with the given backpressure.
   task automatic run_vec(input bit s, input int md, input int bp, input int abort);
      int i, g, w, idx, lat;
      sel = s;
      mode = md;
      lat = s ? 2 : 0;
      compute_model();
      i = 0;
      g = 0;
      while (i < N && g < 500) begin
         @(negedge clk);
         g++;
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
         end else begin
            in_valid = 1'b1;
            in_data  = vx[i];
            if (in_ready_s) i++;
         end
      end
      chk_eq("load_count", i, N);
      chk_eq("busy_load", busy_s, 0);
      for (int k = 0; k < N; k++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = 17'($urandom);
         cur_idx  = k;
         chk_eq("busy_exp", busy_s, 1);
         chk_eq("in_ready_exp", in_ready_s, 0);
         chk_eq("exp_x", exp_x_s, m_ex[k]);
         if (abort == 1 && k == 2) begin
            do_reset();
            return;
         end
      end
      w = 0;
      while (w < 20) begin
         @(negedge clk);
         w++;
         if (out_valid_s) break;
         chk_eq("exp_x_drain", exp_x_s, 0);
         chk_eq("busy_drain", busy_s, 1);
      end
      chk_eq("out_latency", w, 1 + lat);
      idx = 0;
      g = 0;
      while (idx < N && g < 200) begin
         if (g > 0) @(negedge clk);
         g++;
         if (bp == 0)      out_ready = 1'b1;
         else if (bp == 1) out_ready = pat[(g - 1) % 7];
         else              out_ready = 1'($urandom_range(0, 1));
         chk_eq("out_valid", out_valid_s, 1);
         chk_eq("in_ready_out", in_ready_s, 0);
         chk_eq("exp_x_out", exp_x_s, 0);
         chk_eq("out_exp", out_exp_s, m_ey[idx]);
         chk_eq("out_sum", out_sum_s, m_sum);
         chk_eq("out_last", out_last_s, (idx == N - 1));
         if (abort == 2 && idx == 2) begin
            do_reset();
            return;
         end
         if (out_ready) idx++;
         if (idx == N) in_valid = 1'b0;
      end
      chk_eq("out_count", idx, N);
      @(negedge clk);
      out_ready = 1'b0;
      chk_eq("in_ready_next", in_ready_s, 1);
      chk_eq("out_valid_done", out_valid_s, 0);
      chk_eq("busy_done", busy_s, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      @(negedge clk);
      do_reset();
      vx = '{17'h00000, 17'h01000, 17'h02000, 17'h03000};
      run_vec(1'b0, 0, 0, 0);
      vx = '{17'h0A000, 17'h16000, 17'h0A000, 17'h00000};
      run_vec(1'b0, 0, 0, 0);
      rand_vec();
      run_vec(1'b0, 1, 0, 0);
      rand_vec();
      run_vec(1'b0, 2, 0, 0);
      rand_vec();
      run_vec(1'b0, 0, 1, 0);
      vx = '{17'h1F000, 17'h1E000, 17'h1D000, 17'h1C800};
      run_vec(1'b0, 0, 0, 0);
      rand_vec();
      run_vec(1'b1, 3, 0, 0);
      rand_vec();
      run_vec(1'b1, 0, 1, 0);
      rand_vec();
      run_vec(1'b0, 0, 0, 1);
      rand_vec();
      run_vec(1'b0, 0, 2, 0);
      rand_vec();
      run_vec(1'b1, 0, 0, 2);
      rand_vec();
      run_vec(1'b1, 0, 2, 0);
      for (int v = 0; v < 12; v++) begin
         rand_vec();
         run_vec(1'(v % 2), $urandom_range(0, 3), $urandom_range(0, 2), 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
